imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time program loader and port arbiter for the 256-word instruction memory. It receives a byte stream through a valid/ready handshake and packs it into 32-bit big-endian words. It writes those words to consecutive word addresses while holding the CPU in reset. When no load is active, it passes the CPU PC straight through to the memory address port.

Parameters:
DEPTH_WORDS, 256, instruction memory depth in words; the address index is byte address bits [9:2].
LEN_W, 9, width of len_words; must hold the value DEPTH_WORDS.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse; begins a load; sampled only in IDLE
len_words  input  LEN_W  number of words to load, valid range 1..DEPTH_WORDS; sampled with start
abort  input  1  cancels an active load
byte_data  input  8  stream byte
byte_valid  input  1  byte_data is valid
byte_ready  output  1  loader accepts a byte this cycle
cpu_pc  input  32  CPU fetch address
imem_addr  output  32  memory byte address (muxed)
imem_wdata  output  32  assembled word
imem_we  output  1  one-cycle write strobe; memory writes on the rising edge
cpu_hold  output  1  holds the CPU in reset/stall
busy  output  1  a load is in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on a bad length or on abort

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - byte_ready, imem_we, cpu_hold, busy, done, error = 0.
  - imem_wdata=0; word and byte counters = 0.
  - imem_addr follows cpu_pc combinationally.
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - start with len_words in 1..DEPTH_WORDS: latch len_words, go to COLLECT.
  - start with len_words=0 or len_words>DEPTH_WORDS: error=1 for 1 cycle, stay in IDLE.
- COLLECT:
  - byte_ready=1; busy=1; cpu_hold=1.
  - A byte is accepted only when byte_valid && byte_ready.
  - The first byte goes to bits [31:24], then [23:16], [15:8], [7:0] (big-endian).
  - On the 4th accepted byte, go to WRITE.
- WRITE:
  - byte_ready=0; imem_we=1 for exactly this cycle.
  - imem_addr = word_idx*4 (bits [1:0] are always 0).
  - Then word_idx increments. If word_idx+1 == len, go to FINISH; otherwise go to COLLECT.
- FINISH: done=1 for 1 cycle, then go to IDLE. cpu_hold and busy drop on entry to IDLE.
- Address mux: imem_addr = busy ? {22'b0, word_idx[7:0], 2'b00} : cpu_pc. The mux is combinational.
- Latency: start at cycle 0 gives byte_ready=1 from cycle 1. With bytes back-to-back in cycles 1–4, imem_we fires in cycle 5. Each word costs 5 cycles when bytes arrive without gaps; N words take 5N+1 cycles to done.
- Gaps in byte_valid stall COLLECT indefinitely; no timeout.
- abort in COLLECT or WRITE:
  - Takes priority over the pending byte and over the write; imem_we is suppressed that cycle.
  - Partial word discarded; error=1 for 1 cycle; go to IDLE next cycle.
  - Words already written remain in memory.
- start while busy: ignored.
- abort in IDLE: ignored.
- start and abort in the same cycle in IDLE: start wins.
- Reset mid-load: immediate return to IDLE; no done, no error pulse.
- The word counter never wraps. len == DEPTH_WORDS ends after word 255 (address 0x3FC).

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - Adds output checksum[31:0]: modulo-2^32 sum of every word written in the current load.
  - Cleared on accepted start and on reset.
  - Stable and valid from the done pulse until the next start.
- Undefined: the checksum port and its adder do not exist. All other behaviour is identical.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2, FINISH=2'd3.
  - constants BYTES_PER_WORD=4 and IMEM_IDX_LSB=2.
- One natural sub-module: byte_packer. It holds the byte counter and shift register and signals word_full. The FSM, counters and address mux stay at top level.

Test Plan:
1. len=2, bytes 12 34 56 78 9A BC DE F0 back-to-back -> imem_we in cycles 5 and 10. Writes are addr 0x0 data 0x12345678, then addr 0x4 data 0x9ABCDEF0. done in cycle 11; cpu_hold low from cycle 12.
2. len=1 with byte_valid toggling 1/0 -> only valid&&ready bytes are packed; exactly one write, data correct; done once.
3. len=0 start -> error pulse 1 cycle; busy stays 0; imem_addr tracks cpu_pc=0x00400010.
4. len=3, abort after 6 bytes -> one write (word 0) only; error pulse; IDLE next cycle; no done.
5. Reset asserted during WRITE of a len=4 load -> the next edge gives all outputs 0 and IDLE; a fresh len=1 load then succeeds at addr 0x0.
6. len=256 of incrementing words; with IMEM_LOADER_CHECKSUM_EN, checksum equals the reference sum -> last write at addr 0x3FC; start during the load is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int IMEM_IDX_LSB   = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      FINISH  = 2'd3
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready handshake between a byte source (master) and the loader (slave).
interface imem_loader_if;

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_data, output byte_valid, input byte_ready);
   modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into a 32-bit big-endian word; flags the 4th byte of each word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  cnt_r;
   logic [23:0] shift_r;

   // byte position counter and shift register of the three most recent bytes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r   <= 2'd0;
         shift_r <= 24'd0;
      end else if (clear) begin
         cnt_r   <= 2'd0;
         shift_r <= 24'd0;
      end else if (accept) begin
         cnt_r   <= cnt_r + 2'd1;
         shift_r <= {shift_r[15:0], byte_in};
      end else begin
         cnt_r   <= cnt_r;
         shift_r <= shift_r;
      end
   end

   assign word      = {shift_r, byte_in};
   assign word_full = accept && (cnt_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader and address arbiter (CPU PC passes through when idle).
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a 32-bit running checksum output.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LEN_W       = 9
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic             abort,
   imem_loader_if.slave     stream,
   input  logic [31:0]      cpu_pc,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic             imem_we,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]      checksum
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e           state_r, state_s;
   logic [LEN_W-1:0] len_r, word_idx_r;
   logic             ready_r, we_r, busy_r, done_r, error_r;
   logic [31:0]      wdata_r, packed_s;
   logic             accept_s, word_full_s, len_ok_s, start_ok_s, abort_s, last_word_s;

   assign accept_s    = stream.byte_valid && ready_r;
   assign len_ok_s    = (len_words != {LEN_W{1'b0}}) && (len_words <= LEN_W'(DEPTH_WORDS));
   assign start_ok_s  = (state_r == IDLE) && start && len_ok_s;
   assign abort_s     = abort && ((state_r == COLLECT) || (state_r == WRITE));
   assign last_word_s = ((word_idx_r + LEN_W'(1'b1)) == len_r);

   imem_loader_byte_packer u_byte_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start_ok_s || abort_s),
      .accept    (accept_s),
      .byte_in   (stream.byte_data),
      .word      (packed_s),
      .word_full (word_full_s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next-state logic; abort outranks both a completing byte and a pending write
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) state_s = COLLECT;
            else            state_s = IDLE;
         end
         COLLECT: begin
            if (abort)            state_s = IDLE;
            else if (word_full_s) state_s = WRITE;
            else                  state_s = COLLECT;
         end
         WRITE: begin
            if (abort)            state_s = IDLE;
            else if (last_word_s) state_s = FINISH;
            else                  state_s = COLLECT;
         end
         FINISH:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // registered status outputs decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_r <= 1'b0;
         we_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
         wdata_r <= 32'd0;
      end else begin
         ready_r <= (state_s == COLLECT);
         we_r    <= (state_s == WRITE);
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == FINISH);
         error_r <= ((state_r == IDLE) && start && !len_ok_s) || abort_s;
         if (word_full_s && !abort) wdata_r <= packed_s;
         else                       wdata_r <= wdata_r;
      end
   end

   // load length and word index; the index is 9 bits so a full 256-word load never wraps
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_r      <= {LEN_W{1'b0}};
         word_idx_r <= {LEN_W{1'b0}};
      end else if (start_ok_s) begin
         len_r      <= len_words;
         word_idx_r <= {LEN_W{1'b0}};
      end else if ((state_r == WRITE) && !abort) begin
         len_r      <= len_r;
         word_idx_r <= word_idx_r + LEN_W'(1'b1);
      end else begin
         len_r      <= len_r;
         word_idx_r <= word_idx_r;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum_r;

   // running sum of the words committed in the current load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_r <= 32'd0;
      end else if (start_ok_s) begin
         sum_r <= 32'd0;
      end else if (imem_we) begin
         sum_r <= sum_r + imem_wdata;
      end else begin
         sum_r <= sum_r;
      end
   end

   assign checksum = sum_r;
`endif

   assign stream.byte_ready = ready_r;
   assign imem_we    = we_r && !abort;
   assign imem_wdata = wdata_r;
   assign busy       = busy_r;
   assign cpu_hold   = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign imem_addr  = busy_r ? (32'(word_idx_r[IDX_W-1:0]) << IMEM_IDX_LSB) : cpu_pc;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: each load is planned as a cycle timeline from the
// loader's latency rules, then driven and compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int MAXC = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [8:0]  len_words = 9'd0;
   logic [31:0] cpu_pc = 32'd0;
   logic [31:0] imem_addr, imem_wdata;
   logic        imem_we, cpu_hold, busy, done, error;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   imem_loader_if bus ();

   imem_loader u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len_words  (len_words),
      .abort      (abort),
      .stream     (bus),
      .cpu_pc     (cpu_pc),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_we    (imem_we),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   // planned stimulus and expectations, indexed by cycle relative to the start pulse
   bit          d_start [MAXC];
   bit          d_abort [MAXC];
   bit          d_valid [MAXC];
   bit          d_rst   [MAXC];
   logic [8:0]  d_len   [MAXC];
   logic [7:0]  d_data  [MAXC];
   logic [31:0] d_pc    [MAXC];
   bit          e_ready [MAXC];
   bit          e_we    [MAXC];
   bit          e_busy  [MAXC];
   bit          e_done  [MAXC];
   bit          e_err   [MAXC];
   bit          e_wchk  [MAXC];
   bit          e_cschk [MAXC];
   int          e_idx   [MAXC];
   logic [31:0] e_wdata [MAXC];
   logic [31:0] e_cs    [MAXC];

   int          ncyc;
   int          cyc;
   bit          chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] model_sum;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] fixed_byte(input int mode, input int w, input int k);
      logic [31:0] wd;
      if (mode == 1) wd = (w == 0) ? 32'h12345678 : 32'h9ABCDEF0;
      else           wd = 32'h10000000 + 32'(w);
      return wd[31 - 8*k -: 8];
   endfunction

   // Build the timeline: 4 accepted bytes per word, one write cycle after the 4th byte,
   // one done cycle after the last write; abort/reset cut the load short.
   task automatic plan(input int len, input int vpct, input int abort_after, input int abort_wr,
                       input int rst_wr, input int mode, input logic [31:0] pcfix);
      int t, w, k, acc;
      logic [31:0] word, sum;
      bit stop;
      for (int i = 0; i < MAXC; i++) begin
         d_start[i] = 1'b0; d_abort[i] = 1'b0; d_rst[i] = 1'b1;
         d_valid[i] = 1'($urandom_range(1, 0));
         d_len[i]   = 9'($urandom);
         d_data[i]  = 8'($urandom);
         d_pc[i]    = (pcfix != 32'd0) ? pcfix : 32'($urandom);
         e_ready[i] = 1'b0; e_we[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
         e_err[i] = 1'b0; e_wchk[i] = 1'b0; e_cschk[i] = 1'b0;
         e_idx[i] = 0; e_wdata[i] = 32'd0; e_cs[i] = 32'd0;
      end
      d_start[0] = 1'b1;
      d_len[0]   = 9'(len);
      d_abort[0] = ($urandom_range(3, 0) == 0);
      t = 1; stop = 1'b0; sum = 32'd0; acc = 0; w = 0;
      if (len < 1 || len > 256) begin
         e_err[1] = 1'b1;
         stop = 1'b1;
      end
      while (w < len && !stop) begin
         k = 0; word = 32'd0;
         while (k < 4 && !stop) begin
            if (t >= MAXC - 8) begin
               $display("FAIL plan_length: cycle %0d limit %0d", t, MAXC - 8);
               $fatal(1);
            end
            e_ready[t] = 1'b1; e_busy[t] = 1'b1; e_idx[t] = w;
            d_start[t] = ($urandom_range(7, 0) == 0);
            d_valid[t] = ($urandom_range(99, 0) < vpct);
            if (mode != 0) d_data[t] = fixed_byte(mode, w, k);
            if (acc == abort_after) begin
               d_abort[t] = 1'b1; e_err[t+1] = 1'b1; stop = 1'b1;
            end else if (d_valid[t]) begin
               word = {word[23:0], d_data[t]}; k++; acc++;
            end
            t++;
         end
         if (!stop) begin
            e_busy[t] = 1'b1; e_idx[t] = w;
            d_start[t] = ($urandom_range(3, 0) == 0);
            if (w == abort_wr) begin
               d_abort[t] = 1'b1; e_err[t+1] = 1'b1; stop = 1'b1;
            end else begin
               e_we[t] = 1'b1; e_wchk[t] = 1'b1; e_wdata[t] = word; sum = sum + word;
               if (w == rst_wr) begin
                  d_rst[t] = 1'b0; e_wchk[t+1] = 1'b1; e_wdata[t+1] = 32'd0;
                  e_cschk[t+1] = 1'b1; e_cs[t+1] = 32'd0; stop = 1'b1;
               end
            end
            t++; w++;
         end
      end
      if (!stop) begin
         e_busy[t] = 1'b1; e_done[t] = 1'b1; e_idx[t] = len;
         d_start[t] = ($urandom_range(1, 0) == 0);
         for (int i = t; i < t + 3; i++) begin
            e_cschk[i] = 1'b1; e_cs[i] = sum;
         end
         t++;
      end
      for (int i = t; i < MAXC; i++) begin
         d_start[i] = 1'b0;
         d_abort[i] = ($urandom_range(3, 0) == 0);
      end
      model_sum = sum;
      ncyc = t + 2;
   endtask

   task automatic run();
      for (int t = 0; t < ncyc; t++) begin
         @(posedge clk); #1;
         rst_n = d_rst[t]; start = d_start[t]; len_words = d_len[t]; abort = d_abort[t];
         bus.byte_valid = d_valid[t]; bus.byte_data = d_data[t]; cpu_pc = d_pc[t];
         cyc = t; chk_en = 1'b1;
      end
      @(posedge clk); #1;
      chk_en = 1'b0; rst_n = 1'b1; start = 1'b0; abort = 1'b0; bus.byte_valid = 1'b0;
   endtask

   // per-cycle comparison of every output against the planned timeline
   always @(negedge clk) begin
      if (chk_en) begin
         chk32("byte_ready", 32'(bus.byte_ready), 32'(e_ready[cyc]));
         chk32("imem_we",    32'(imem_we),        32'(e_we[cyc]));
         chk32("busy",       32'(busy),           32'(e_busy[cyc]));
         chk32("cpu_hold",   32'(cpu_hold),       32'(e_busy[cyc]));
         chk32("done",       32'(done),           32'(e_done[cyc]));
         chk32("error",      32'(error),          32'(e_err[cyc]));
         chk32("imem_addr",  imem_addr,
               e_busy[cyc] ? (32'(e_idx[cyc] % 256) * 32'd4) : d_pc[cyc]);
         if (e_wchk[cyc]) chk32("imem_wdata", imem_wdata, e_wdata[cyc]);
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (e_cschk[cyc]) chk32("checksum", checksum, e_cs[cyc]);
`endif
      end
   end

   initial begin
      int len, vpct, ab, abw;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'd0;
      cyc = 0;
      rst_n = 1'b0; cpu_pc = 32'h00001234;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk32("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk32("rst_we",         32'(imem_we),        32'd0);
      chk32("rst_busy",       32'(busy),           32'd0);
      chk32("rst_hold",       32'(cpu_hold),       32'd0);
      chk32("rst_done",       32'(done),           32'd0);
      chk32("rst_error",      32'(error),          32'd0);
      chk32("rst_wdata",      imem_wdata,          32'd0);
      chk32("rst_addr",       imem_addr,           32'h00001234);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk32("rst_checksum",   checksum,            32'd0);
`endif
      @(posedge clk); #1 rst_n = 1'b1;

      // two-word load with fixed bytes; pin the model's timing and data
      plan(2, 100, -1, -1, -1, 1, 32'd0);
      chk32("model_we5",    32'(e_we[5]),  32'd1);
      chk32("model_wd5",    e_wdata[5],    32'h12345678);
      chk32("model_we10",   32'(e_we[10]), 32'd1);
      chk32("model_wd10",   e_wdata[10],   32'h9ABCDEF0);
      chk32("model_done11", 32'(e_done[11]), 32'd1);
      chk32("model_idle12", 32'(e_busy[12]), 32'd0);
      run();

      plan(1, 50, -1, -1, -1, 0, 32'd0);
      run();
      plan(0, 100, -1, -1, -1, 0, 32'h00400010);
      run();
      plan(300, 100, -1, -1, -1, 0, 32'h00400010);
      run();
      plan(3, 100, 6, -1, -1, 0, 32'd0);
      run();
      plan(4, 100, -1, -1, 1, 0, 32'd0);
      run();
      plan(1, 100, -1, -1, -1, 0, 32'd0);
      run();
      plan(2, 100, -1, 1, -1, 0, 32'd0);
      run();

      plan(256, 100, -1, -1, -1, 2, 32'd0);
      chk32("model_sum256",   model_sum,            32'h00007F80);
      chk32("model_lastwe",   32'(e_we[1280]),      32'd1);
      chk32("model_lastaddr", 32'(e_idx[1280] * 4), 32'h000003FC);
      chk32("model_done256",  32'(e_done[1281]),    32'd1);
      run();

      for (int n = 0; n < 10; n++) begin
         len  = $urandom_range(8, 1);
         vpct = $urandom_range(100, 30);
         ab   = ($urandom_range(3, 0) == 0) ? $urandom_range(4 * len - 1, 0) : -1;
         abw  = ($urandom_range(4, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
         plan(len, vpct, ab, abw, -1, 0, 32'd0);
         run();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
